param_processor: RTL and testbench
==================================

Name: param_processor

Overview:
- Parametrised multi-cycle successor to the 4-bit combinational processor: register file, ALU and flags, generalised in data width and register count.
- Adds a start/busy/done handshake, registered flags, immediate load and register move.
- Each operation is captured, read, executed and written back over a fixed 4-state FSM.
- Sits between the instruction-issue logic and the flag/result consumers in the lab datapath.

Parameters:
- WIDTH, 4, data width of registers, ALU and result.
- ADDR_W, 2, register address width; register count NREGS = 2**ADDR_W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only in IDLE.
- opcode  in  3  operation select (see Behaviour).
- rd  in  ADDR_W  destination register address.
- rs1  in  ADDR_W  source register 1 address.
- rs2  in  ADDR_W  source register 2 address.
- imm  in  WIDTH  immediate data for LDI.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  WIDTH  combinational read of register[dbg_addr].
- busy  out  1  high in READ, EXEC and WB.
- done  out  1  one-cycle pulse in WB.
- result  out  WIDTH  registered result of the last completed operation.
- flag_carry  out  1  registered carry/borrow flag.
- flag_zero  out  1  registered zero flag.
- flag_negative  out  1  registered negative flag (result MSB).
- invalid  out  1  registered: last operation had an invalid opcode.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all NREGS registers=0; result=0; every flag, invalid, busy and done=0. Reset wins over all other inputs.
- Reset mid-operation aborts the operation; no register write occurs.
- FSM:
  - IDLE: if start=1, capture opcode/rd/rs1/rs2/imm into internal registers, go to READ. Otherwise stay in IDLE.
  - READ: latch reg[rs1] and reg[rs2] into operand registers, go to EXEC.
  - EXEC: compute the ALU value and next flags into pipeline registers, go to WB.
  - WB: write reg[rd] if the operation writes; update result, flags and invalid; done=1; go to IDLE.
- Latency: start accepted at edge N; done high in the cycle after edge N+3; result and flags valid from the same edge and held until the next WB.
- Throughput: at most one operation per 4 cycles. start held high gives back-to-back operations with one IDLE cycle between them.
- start while busy is ignored (not queued). Inputs other than start matter only at the capture edge.
- Opcodes (WIDTH-bit arithmetic, wrap-around modulo 2**WIDTH):
  - 000 ADD: rd=rs1+rs2; carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - 001 SUB: rd=rs1-rs2; carry = borrow (1 when rs1<rs2, unsigned).
  - 010 AND: rd=rs1&rs2; carry=0.
  - 011 OR: rd=rs1|rs2; carry=0.
  - 100 LDI: rd=imm; carry=0.
  - 101 MOV: rd=reg[rs1]; carry=0.
  - 110, 111: invalid. No register write; result=0; carry, zero and negative=0; invalid=1.
- For valid opcodes: invalid=0; zero = (value==0); negative = value[WIDTH-1].
- rd may equal rs1 or rs2: operands are latched in READ, so the old values are used.
- A following operation's READ sees the value written by the previous WB (write lands at the WB edge).
- Register 0 is an ordinary writable register.
- dbg_data is combinational and reflects a write on the edge after WB.

Test Plan (WIDTH=4, ADDR_W=2):
- Reset, then dbg_addr 0..3 -> dbg_data=0 for all; result=0; all flags=0; busy=0.
- LDI r1=4'h9, LDI r2=4'h7, ADD rd=r3 rs1=r1 rs2=r2 -> r3=4'h0; carry=1; zero=1; negative=0; done pulses once, 3 cycles after each accepted start.
- SUB r0=r2-r1 (7-9) -> r0=4'hE; carry(borrow)=1; negative=1; zero=0. Then SUB r0=r1-r2 -> 4'h2; carry=0.
- Opcode 111 with rd=r1 -> invalid=1; result=0; all flags=0; r1 still 4'h9. A following MOV r2=r1 -> invalid=0; r2=4'h9; negative=1.
- start pulsed during READ and EXEC of an AND -> ignored; exactly one done pulse; start held high continuously -> done every 4 cycles.
- reset asserted in EXEC of LDI r3=4'hF -> r3 stays 0; state IDLE; done never pulses.

Source files
------------

// File: rtl/param_processor.sv
// ---------------------------------------------------------------------------
// param_processor
//   Parametrised multi-cycle register-file processor. Each accepted operation
//   walks IDLE -> READ -> EXEC -> WB: capture the instruction, latch both
//   source operands, compute the ALU value and flags, then write back.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start               request an operation (sampled only in IDLE)
//   opcode, rd, rs1,
//   rs2, imm            instruction fields, captured with start
//   dbg_addr / dbg_data combinational register-file read port
//   busy                high while READ, EXEC or WB is in progress
//   done                one-cycle pulse when an operation completes
//   result              value of the last completed operation
//   flag_carry/zero/
//   negative, invalid   status of the last completed operation
// ---------------------------------------------------------------------------
module param_processor #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [WIDTH-1:0]  imm,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic              flag_carry,
    output logic              flag_zero,
    output logic              flag_negative,
    output logic              invalid
);

    localparam int unsigned NREGS = 1 << ADDR_W;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_LDI = 3'b100;
    localparam logic [2:0] OP_MOV = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t state_q;

    // Register file
    logic [WIDTH-1:0]  rf_q [NREGS];

    // Captured instruction
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [ADDR_W-1:0] rs1_q;
    logic [ADDR_W-1:0] rs2_q;
    logic [WIDTH-1:0]  imm_q;

    // Operands latched in READ
    logic [WIDTH-1:0]  opa_q;
    logic [WIDTH-1:0]  opb_q;

    // EXEC -> WB pipeline registers
    logic [WIDTH-1:0]  ex_val_q;
    logic              ex_carry_q;
    logic              ex_zero_q;
    logic              ex_neg_q;
    logic              ex_we_q;
    logic              ex_inv_q;

    // Architectural outputs
    logic [WIDTH-1:0]  result_q;
    logic              carry_q;
    logic              zero_q;
    logic              neg_q;
    logic              invalid_q;
    logic              busy_q;
    logic              done_q;

    // ALU next values, consumed at the EXEC edge
    logic [WIDTH:0]    sum_w;
    logic [WIDTH:0]    diff_w;
    logic [WIDTH-1:0]  alu_val_d;
    logic              alu_carry_d;
    logic              alu_zero_d;
    logic              alu_neg_d;
    logic              alu_we_d;
    logic              alu_inv_d;

    // ALU: one extra bit on add/sub exposes carry-out and unsigned borrow
    always_comb begin
        sum_w       = {1'b0, opa_q} + {1'b0, opb_q};
        diff_w      = {1'b0, opa_q} - {1'b0, opb_q};
        alu_val_d   = '0;
        alu_carry_d = 1'b0;
        alu_we_d    = 1'b1;
        alu_inv_d   = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_val_d   = sum_w[WIDTH-1:0];
                alu_carry_d = sum_w[WIDTH];
            end
            OP_SUB: begin
                alu_val_d   = diff_w[WIDTH-1:0];
                alu_carry_d = diff_w[WIDTH];
            end
            OP_AND:  alu_val_d = opa_q & opb_q;
            OP_OR:   alu_val_d = opa_q | opb_q;
            OP_LDI:  alu_val_d = imm_q;
            OP_MOV:  alu_val_d = opa_q;
            default: begin
                alu_we_d  = 1'b0;
                alu_inv_d = 1'b1;
            end
        endcase
        // Invalid opcodes report all flags clear, including zero
        alu_zero_d = ~alu_inv_d & (alu_val_d == '0);
        alu_neg_d  = alu_val_d[WIDTH-1];
    end

    // Sequencer, register file and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rf_q       <= '{default: '0};
            op_q       <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            ex_val_q   <= '0;
            ex_carry_q <= 1'b0;
            ex_zero_q  <= 1'b0;
            ex_neg_q   <= 1'b0;
            ex_we_q    <= 1'b0;
            ex_inv_q   <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            invalid_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= opcode;
                        rd_q    <= rd;
                        rs1_q   <= rs1;
                        rs2_q   <= rs2;
                        imm_q   <= imm;
                        busy_q  <= 1'b1;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    // Operands are frozen here, so rd == rs1/rs2 uses old values
                    opa_q   <= rf_q[rs1_q];
                    opb_q   <= rf_q[rs2_q];
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    ex_val_q   <= alu_val_d;
                    ex_carry_q <= alu_carry_d;
                    ex_zero_q  <= alu_zero_d;
                    ex_neg_q   <= alu_neg_d;
                    ex_we_q    <= alu_we_d;
                    ex_inv_q   <= alu_inv_d;
                    state_q    <= S_WB;
                end
                S_WB: begin
                    if (ex_we_q) begin
                        rf_q[rd_q] <= ex_val_q;
                    end
                    result_q  <= ex_val_q;
                    carry_q   <= ex_carry_q;
                    zero_q    <= ex_zero_q;
                    neg_q     <= ex_neg_q;
                    invalid_q <= ex_inv_q;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dbg_data      = rf_q[dbg_addr];
    assign busy          = busy_q;
    assign done          = done_q;
    assign result        = result_q;
    assign flag_carry    = carry_q;
    assign flag_zero     = zero_q;
    assign flag_negative = neg_q;
    assign invalid       = invalid_q;

endmodule

// File: tb/tb_param_processor.sv
// ---------------------------------------------------------------------------
// tb_param_processor
//   Driver issues directed and random operations; an abstract model predicts
//   which start pulses are accepted, the completion cycle and the outputs,
//   and pushes them into a scoreboard queue. A negedge monitor pops and
//   compares whenever done is seen (or when a predicted done is overdue).
// ---------------------------------------------------------------------------
module tb_param_processor;

    localparam int unsigned W = 4;
    localparam int unsigned A = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   opcode = '0;
    logic [A-1:0] rd = '0;
    logic [A-1:0] rs1 = '0;
    logic [A-1:0] rs2 = '0;
    logic [W-1:0] imm = '0;
    logic [A-1:0] dbg_addr = '0;
    logic [W-1:0] dbg_data;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         flag_carry;
    logic         flag_zero;
    logic         flag_negative;
    logic         invalid;

    param_processor #(.WIDTH(W), .ADDR_W(A)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .opcode        (opcode),
        .rd            (rd),
        .rs1           (rs1),
        .rs2           (rs2),
        .imm           (imm),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .flag_carry    (flag_carry),
        .flag_zero     (flag_zero),
        .flag_negative (flag_negative),
        .invalid       (invalid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int             cyc_exp;
        logic [3:0]     res;
        logic           c;
        logic           z;
        logic           n;
        logic           inv;
        logic [3:0][3:0] regs;
    } exp_t;

    exp_t            sb_q[$];
    logic [3:0][3:0] mregs = '0;
    int              cyc = 0;
    int              next_accept = 0;
    int              last_accept = -100;
    int              n_checks = 0;
    int              n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Abstract model of one operation, applied at the accept edge
    task automatic accept();
        exp_t it;
        int   a;
        int   b;
        int   v;
        bit   c;
        bit   inv;
        a   = int'(mregs[rs1]);
        b   = int'(mregs[rs2]);
        c   = 1'b0;
        inv = 1'b0;
        case (opcode)
            3'd0: begin v = a + b; c = (v >= 16); v = v % 16; end
            3'd1: begin c = (a < b); v = (a - b + 16) % 16; end
            3'd2: v = a & b;
            3'd3: v = a | b;
            3'd4: v = int'(imm);
            3'd5: v = a;
            default: begin v = 0; inv = 1'b1; end
        endcase
        if (!inv) mregs[rd] = 4'(v);
        it.cyc_exp = cyc + 3;
        it.res     = 4'(v);
        it.c       = c;
        it.z       = !inv && (v == 0);
        it.n       = (v >= 8);
        it.inv     = inv;
        it.regs    = mregs;
        sb_q.push_back(it);
        last_accept = cyc;
        next_accept = cyc + 4;
    endtask

    // One clock edge with the currently driven inputs
    task automatic tick();
        dbg_addr = A'($urandom_range(0, 3));
        if (!start) begin
            opcode = 3'($urandom_range(0, 7));
            rd     = A'($urandom_range(0, 3));
            rs1    = A'($urandom_range(0, 3));
            rs2    = A'($urandom_range(0, 3));
            imm    = W'($urandom_range(0, 15));
        end
        @(posedge clk);
        cyc++;
        if (reset) begin
            sb_q.delete();
            mregs       = '0;
            last_accept = -100;
            next_accept = cyc + 1;
        end else if (start && cyc >= next_accept) begin
            accept();
        end
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] d, input logic [1:0] s1,
                         input logic [1:0] s2, input logic [3:0] im);
        int guard;
        guard = 0;
        start = 1'b0;
        while (cyc + 1 < next_accept && guard < 10) begin
            tick();
            guard++;
        end
        opcode = op; rd = d; rs1 = s1; rs2 = s2; imm = im;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        start = 1'b0;
        while (sb_q.size() > 0 && guard < 20) begin
            tick();
            guard++;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
        tick();
    endtask

    task automatic sweep(input string name);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = A'(i);
            #1;
            check(name, 32'(dbg_data), 32'(mregs[i]));
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (cyc >= 1) begin
            check("busy", 32'(busy), 32'((cyc - last_accept) >= 0 && (cyc - last_accept) <= 2));
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t it;
                    it = sb_q.pop_front();
                    check("done_cycle", 32'(cyc), 32'(it.cyc_exp));
                    check("result", 32'(result), 32'(it.res));
                    check("carry", 32'(flag_carry), 32'(it.c));
                    check("zero", 32'(flag_zero), 32'(it.z));
                    check("negative", 32'(flag_negative), 32'(it.n));
                    check("invalid", 32'(invalid), 32'(it.inv));
                    check("dbg_reg", 32'(dbg_data), 32'(it.regs[dbg_addr]));
                end
            end else if (sb_q.size() > 0 && cyc >= sb_q[0].cyc_exp) begin
                exp_t it;
                it = sb_q.pop_front();
                check("missing_done", 32'(done), 32'd1);
            end
        end
    end

    initial begin
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        sweep("reset_reg");
        check("reset_result", 32'(result), 32'd0);
        check("reset_flags", 32'({flag_carry, flag_zero, flag_negative, invalid}), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);

        // Directed sequence
        issue(3'd4, 2'd1, 2'd0, 2'd0, 4'h9);
        issue(3'd4, 2'd2, 2'd0, 2'd0, 4'h7);
        issue(3'd0, 2'd3, 2'd1, 2'd2, 4'h0);
        issue(3'd1, 2'd0, 2'd2, 2'd1, 4'h0);
        issue(3'd1, 2'd0, 2'd1, 2'd2, 4'h0);
        issue(3'd7, 2'd1, 2'd2, 2'd3, 4'h3);
        issue(3'd5, 2'd2, 2'd1, 2'd0, 4'h0);
        drain();
        sweep("directed_reg");

        // start pulses while busy are ignored
        issue(3'd2, 2'd3, 2'd1, 2'd2, 4'h0);
        start = 1'b1; tick();
        start = 1'b1; tick();
        drain();

        // start held high: one operation every 4 cycles
        start = 1'b1;
        for (int k = 0; k < 16; k++) begin
            opcode = 3'($urandom_range(0, 5));
            rd     = A'($urandom_range(0, 3));
            rs1    = A'($urandom_range(0, 3));
            rs2    = A'($urandom_range(0, 3));
            imm    = W'($urandom_range(0, 15));
            tick();
        end
        drain();

        // reset during EXEC of LDI r3=F aborts the write
        issue(3'd4, 2'd3, 2'd0, 2'd0, 4'hF);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        dbg_addr = 2'd3;
        #1;
        check("abort_r3", 32'(dbg_data), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        for (int k = 0; k < 6; k++) tick();

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            start = 1'($urandom_range(0, 1));
            if (start) begin
                opcode = 3'($urandom_range(0, 7));
                rd     = A'($urandom_range(0, 3));
                rs1    = A'($urandom_range(0, 3));
                rs2    = A'($urandom_range(0, 3));
                imm    = W'($urandom_range(0, 15));
            end
            tick();
        end
        drain();
        sweep("final_reg");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
